multdiv_controller: RTL
=======================

# multdiv_controller

Multi-cycle signed multiply/divide sequencer attached to the execute stage of the pipelined processor. It accepts a mul or div request from decode/execute, runs a 32-iteration shift-add (multiply) or restoring (divide) engine, and holds `stall` so the PC, F/D latch and D/X latch freeze until the result is ready. It produces a one-cycle result strobe for the X/M latch and reports overflow or divide-by-zero.

## Interface
- WIDTH, 32, operand/result width
- ITER, WIDTH, iterations per operation; counter width is clog2(ITER)+1

- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- ctrl_mult  in  1  start signed multiply; sampled in IDLE or DONE
- ctrl_div  in  1  start signed divide; sampled in IDLE or DONE
- data_operandA  in  WIDTH  multiplicand / dividend, captured on accepted start
- data_operandB  in  WIDTH  multiplier / divisor, captured on accepted start
- flush  in  1  squash in-flight op (branch/jump kill)
- stall  out  1  hold upstream pipeline
- data_result  out  WIDTH  product low word / quotient; held until next strobe
- data_exception  out  1  overflow / div-by-zero, valid with data_resultRDY, held
- data_resultRDY  out  1  one-cycle result strobe

## Operation
- States: IDLE, MULT, DIV, DONE.
- IDLE/DONE + ctrl_mult → MULT, count=0. IDLE/DONE + ctrl_div (ctrl_mult low) → DIV, or → DONE directly if operandB==0.
- Both starts high: multiply wins; ctrl_div is ignored.
- Starts seen in MULT/DIV are ignored.
- Operands are captured as magnitudes. The result sign is the XOR of the operand signs. Negation is applied in the final iteration.
- MULT: one shift-add step per cycle into a 2·WIDTH accumulator. After ITER steps → DONE.
- Multiply overflow: exception = 1 when the signed 64-bit product's upper 33 bits are not all equal. Result is still the low 32 bits.
- DIV: one restoring subtract step per cycle. After ITER steps → DONE. Quotient truncates toward zero; the remainder is discarded.
- Divide by zero: result 0, exception 1.
- 0x80000000 / −1: result 0x80000000, exception 1.
- DONE lasts one cycle: data_resultRDY=1, data_result and data_exception update, then → IDLE unless a new start is accepted.
- flush in MULT/DIV: → IDLE next edge, no strobe, data_result and data_exception keep old values.
- flush in IDLE/DONE suppresses a coincident start.
- reset low at any time: state IDLE, count 0, all outputs 0 (stall 0, data_result 0, data_exception 0, data_resultRDY 0), independent of clock.

## Timing
- Cycle 0 = cycle in which the start is high in IDLE/DONE.
- stall is combinational: high in cycle 0 when a start is accepted, and high throughout MULT/DIV. It is low in DONE and IDLE.
- Normal op: MULT/DIV occupies cycles 1..ITER. DONE, with data_resultRDY high, is in cycle ITER+1 (33 for the default).
- Divide by zero: DONE in cycle 1; stall high in cycle 0 only.
- Back-to-back: a start accepted in a DONE cycle begins MULT/DIV in the next cycle. Throughput is one op per ITER+1 cycles.
- Flush sampled high in cycle k (1 ≤ k ≤ ITER): stall is low in cycle k+1.

## Structure
- Package `multdiv_pkg` holds:
  - state enum (IDLE, MULT, DIV, DONE)
  - WIDTH default
  - constant MIN_NEG = 32'h8000_0000
- Sub-module `multdiv_step`: purely combinational single iteration. It takes accumulator, operand and mode, and returns the next accumulator. Multiply mode adds and shifts; divide mode does a trial subtract and restore.
- The controller owns the FSM, counter, operand and sign registers, and output registers.

## Test plan
- Multiply 7 × 6 from reset: stall high cycles 0–32; cycle 33 data_resultRDY=1, data_result=42, data_exception=0; data_resultRDY low in cycle 34.
- Multiply −3 × 5 → 0xFFFFFFF1, exc 0. Multiply 0x00010000 × 0x00010000 → result 0x00000000, exc 1.
- Divide 100 / −7 → 0xFFFFFFF2, exc 0 at cycle 33. Divide 7 / 0 → result 0, exc 1, strobe in cycle 1, stall high in cycle 0 only.
- Divide 0x80000000 / 0xFFFFFFFF → 0x80000000, exc 1. Multiply 0x7FFFFFFF × 2 → 0xFFFFFFFE, exc 1.
- Multiply started; flush high in cycle 10:
  - stall low from cycle 11; no strobe.
  - data_result keeps the prior value.
  - A start in cycle 12 completes normally in cycle 45.
- reset driven low mid-divide (cycle 15, between clock edges): all outputs 0 immediately.
  - After release, state is IDLE.
  - A new divide 9 / 3 → 3 at cycle 33.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Imported by the controller and its iteration datapath.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the engine: shift-add for multiply,
// trial subtract and restore for divide.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] shl;
    logic [WIDTH-1:0]   addend;

    always_comb begin
        addend = acc[0] ? operand : '0;
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        shl    = {acc[2*WIDTH-2:0], 1'b0};
        diff   = {1'b0, shl[2*WIDTH-1:WIDTH]} - {1'b0, operand};
        if (div_mode) begin
            // Borrow out means the trial subtract failed: keep the shifted value.
            acc_next = diff[WIDTH] ? shl
                                   : {diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/multdiv_controller.sv
// Multi-cycle signed mul/div sequencer for the execute stage.
// Stalls upstream while iterating and strobes the result for X/M.
module multdiv_controller
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             flush,
    output logic             stall,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CW = $clog2(ITER) + 1;
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_NEG);

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   res_val;
    logic               res_exc;
    logic               neg;
    logic               div_ovf;
    logic               busy;
    logic               can_start;
    logic               go_mult;
    logic               go_div;
    logic               div_zero;
    logic               last;
    logic               stall_c;

    assign busy      = (state == MULT) || (state == DIV);
    assign can_start = !busy && !flush;
    assign go_mult   = can_start && ctrl_mult;
    assign go_div    = can_start && !ctrl_mult && ctrl_div;
    assign div_zero  = (data_operandB == '0);
    assign last      = busy && !flush && (count == CW'(ITER - 1));

    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    multdiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc),
        .operand (opnd),
        .div_mode(state == DIV),
        .acc_next(acc_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall_c    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                stall_c = go_mult || go_div;
                if (go_mult) begin
                    state_next = MULT;
                end else if (go_div) begin
                    state_next = div_zero ? DONE : DIV;
                end else begin
                    state_next = IDLE;
                end
            end
            MULT, DIV: begin
                stall_c = 1'b1;
                if (flush) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign stall          = stall_c & reset;
    assign data_resultRDY = (state == DONE);

    // Sign is applied to the value leaving the final iteration.
    always_comb begin
        prod    = neg ? -acc_next : acc_next;
        quot    = neg ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        res_val = quot;
        res_exc = div_ovf;
        if (state == MULT) begin
            res_val = prod[WIDTH-1:0];
            res_exc = !((&prod[2*WIDTH-1:WIDTH-1]) ||
                        !(|prod[2*WIDTH-1:WIDTH-1]));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count          <= '0;
            acc            <= '0;
            opnd           <= '0;
            neg            <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (go_mult) begin
            count   <= '0;
            acc     <= {{WIDTH{1'b0}}, b_mag};
            opnd    <= a_mag;
            neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_ovf <= 1'b0;
        end else if (go_div) begin
            count   <= '0;
            acc     <= {{WIDTH{1'b0}}, a_mag};
            opnd    <= b_mag;
            neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_ovf <= (data_operandA == MIN_W) && (data_operandB == '1);
            if (div_zero) begin
                data_result    <= '0;
                data_exception <= 1'b1;
            end
        end else if (busy) begin
            count <= flush ? '0 : count + CW'(1);
            acc   <= acc_next;
            if (last) begin
                data_result    <= res_val;
                data_exception <= res_exc;
            end
        end
    end

endmodule
